// File: rtl/serial_pkg.sv
// Shared defaults, FSM encoding and helpers for serial_arbiter and its per-channel slots.
package serial_pkg;

  localparam int unsigned DATA_W_DEF     = 17;
  localparam int unsigned TS_W_DEF       = 24;
  localparam int unsigned GAP_CYCLES_DEF = 8400;
  localparam int unsigned DROP_W         = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OFFER = 2'd1,
    ST_LOAD  = 2'd2,
    ST_GAP   = 2'd3
  } arb_state_e;

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (v == {DROP_W{1'b1}}) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/serial_arb_slot.sv
// One channel's capture slot: result register, pending flag, decoder clear pulse, overrun counter.
// OVERWRITE_EN: a full slot is replaced by newer data and the overrun is counted (saturating).
module serial_arb_slot
  import serial_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned TS_W   = TS_W_DEF
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              avail_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [TS_W-1:0]   ts_i,
  input  logic              grant_i,
  output logic              pending_o,
  output logic [DATA_W-1:0] data_o,
  output logic [TS_W-1:0]   ts_o,
  output logic              clr_o,
  output logic [DROP_W-1:0] drop_o
);

  logic              pending_q, pending_d;
  logic              clr_q;
  logic              capture_s;
  logic [DATA_W-1:0] data_q, data_d;
  logic [TS_W-1:0]   ts_q, ts_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  // clr_q masks capture while the decoder still shows the result it is being told to clear.
  always_comb begin
    capture_s = 1'b0;
    drop_d    = drop_q;
`ifdef OVERWRITE_EN
    capture_s = avail_i && !clr_q;
    if (capture_s && pending_q && !grant_i) begin
      drop_d = sat_inc(drop_q);
    end else begin
      drop_d = drop_q;
    end
`else
    capture_s = avail_i && !clr_q && (!pending_q || grant_i);
    drop_d    = '0;
`endif
    if (capture_s) begin
      pending_d = 1'b1;
      data_d    = data_i;
      ts_d      = ts_i;
    end else if (grant_i) begin
      pending_d = 1'b0;
      data_d    = data_q;
      ts_d      = ts_q;
    end else begin
      pending_d = pending_q;
      data_d    = data_q;
      ts_d      = ts_q;
    end
  end

  // Slot state register.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      pending_q <= 1'b0;
      clr_q     <= 1'b0;
      data_q    <= '0;
      ts_q      <= '0;
      drop_q    <= '0;
    end else begin
      pending_q <= pending_d;
      clr_q     <= capture_s;
      data_q    <= data_d;
      ts_q      <= ts_d;
      drop_q    <= drop_d;
    end
  end

  assign pending_o = pending_q;
  assign data_o    = data_q;
  assign ts_o      = ts_q;
  assign clr_o     = clr_q;
  assign drop_o    = drop_q;

endmodule

// File: rtl/serial_arbiter.sv
// Round-robin arbiter sharing one serial transmitter among N_CH decoder channels.
// Optional OVERWRITE_EN macro: full slots are overwritten and overruns counted in drop_count.
module serial_arbiter
  import serial_pkg::*;
#(
  parameter  int unsigned N_CH       = 4,
  parameter  int unsigned DATA_W     = DATA_W_DEF,
  parameter  int unsigned TS_W       = TS_W_DEF,
  parameter  int unsigned GAP_CYCLES = GAP_CYCLES_DEF,
  localparam int unsigned ID_W       = $clog2(N_CH),
  localparam int unsigned CNT_W      = $clog2(GAP_CYCLES + 1)
) (
  input  logic                   clk_12MHz,
  input  logic                   rstn,
  input  logic [N_CH-1:0]        ch_data_available,
  input  logic [N_CH*DATA_W-1:0] ch_decoded_data,
  input  logic [N_CH*TS_W-1:0]   ch_timestamp,
  output logic [N_CH-1:0]        ch_reset_decoder,
  output logic                   tx_data_available,
  output logic [DATA_W-1:0]      tx_decoded_data,
  output logic [TS_W-1:0]        tx_timestamp,
  output logic [ID_W-1:0]        tx_sensor_id,
  input  logic                   tx_reset_decoder,
  output logic [N_CH*DROP_W-1:0] drop_count
);

  logic [N_CH-1:0]   pending_s, grant_s, clr_s;
  logic [DATA_W-1:0] slot_data_s [N_CH];
  logic [TS_W-1:0]   slot_ts_s   [N_CH];

  arb_state_e        state_q, state_d;
  logic [ID_W-1:0]   rr_q, rr_d, id_q, id_d, pick_s, idx_s;
  logic              any_s;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              txv_q, txv_d;
  logic [DATA_W-1:0] txd_q, txd_d;
  logic [TS_W-1:0]   txts_q, txts_d;

  for (genvar i = 0; i < N_CH; i++) begin : g_slot
    serial_arb_slot #(
      .DATA_W (DATA_W),
      .TS_W   (TS_W)
    ) u_slot (
      .clk_i     (clk_12MHz),
      .rstn_i    (rstn),
      .avail_i   (ch_data_available[i]),
      .data_i    (ch_decoded_data[i*DATA_W +: DATA_W]),
      .ts_i      (ch_timestamp[i*TS_W +: TS_W]),
      .grant_i   (grant_s[i]),
      .pending_o (pending_s[i]),
      .data_o    (slot_data_s[i]),
      .ts_o      (slot_ts_s[i]),
      .clr_o     (clr_s[i]),
      .drop_o    (drop_count[i*DROP_W +: DROP_W])
    );
  end

  assign ch_reset_decoder = clr_s;

  // Scan downwards so the lowest offset from rr_q (first at or after it) wins.
  always_comb begin
    pick_s = '0;
    idx_s  = '0;
    any_s  = |pending_s;
    for (int k = N_CH - 1; k >= 0; k--) begin
      idx_s = ID_W'((int'(rr_q) + k) % int'(N_CH));
      if (pending_s[idx_s]) begin
        pick_s = idx_s;
      end else begin
        pick_s = pick_s;
      end
    end
  end

  // Grant is taken in IDLE only; the slot frees itself in the same cycle.
  always_comb begin
    grant_s = '0;
    if (state_q == ST_IDLE && any_s) begin
      grant_s[pick_s] = 1'b1;
    end else begin
      grant_s = '0;
    end
  end

  // Next-state and tx register logic.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    txv_d   = txv_q;
    txd_d   = txd_q;
    txts_d  = txts_q;
    id_d    = id_q;
    case (state_q)
      ST_IDLE: begin
        if (any_s) begin
          txd_d   = slot_data_s[pick_s];
          txts_d  = slot_ts_s[pick_s];
          id_d    = pick_s;
          txv_d   = 1'b1;
          state_d = ST_OFFER;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_OFFER: begin
        if (tx_reset_decoder) begin
          txv_d   = 1'b0;
          rr_d    = (id_q == ID_W'(N_CH - 1)) ? '0 : id_q + ID_W'(1);
          state_d = ST_LOAD;
        end else begin
          state_d = ST_OFFER;
        end
      end
      ST_LOAD: begin
        cnt_d   = CNT_W'(GAP_CYCLES - 1);
        state_d = ST_GAP;
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM, pointer, gap counter and tx registers.
  always_ff @(posedge clk_12MHz) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      rr_q    <= '0;
      cnt_q   <= '0;
      txv_q   <= 1'b0;
      txd_q   <= '0;
      txts_q  <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      txv_q   <= txv_d;
      txd_q   <= txd_d;
      txts_q  <= txts_d;
      id_q    <= id_d;
    end
  end

  assign tx_data_available = txv_q;
  assign tx_decoded_data   = txd_q;
  assign tx_timestamp      = txts_q;
  assign tx_sensor_id      = id_q;

endmodule
